// File: rtl/pin_scan_pkg.sv
// Shared constants, receiver state encoding and one-hot decode helpers
// for the rotating scan-line receiver.
package pin_scan_pkg;

  localparam int NUM_PINS = 6;
  localparam int IDX_W    = 3;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  typedef logic [NUM_PINS-1:0] pins_t;

  function automatic logic is_one_hot(input pins_t p);
    return (p != '0) && ((p & (p - pins_t'(1))) == '0);
  endfunction

  // Only meaningful when is_one_hot(p) holds; otherwise returns the highest set bit.
  function automatic logic [IDX_W-1:0] onehot_to_index(input pins_t p);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      if (p[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchroniser for a bus of independent asynchronous lines;
// every bit is synchronised on its own, no bus coherency is implied.
module pin_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain [STAGES];

  // NOTE: the flop chain is a handful of registers, not a RAM, so clearing it on reset is cheap and keeps stale lines from leaking into the first decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) chain[i] <= '0;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pin_scan_reader.sv
// Receiver for a rotating one-hot scan: synchronises A0..A5, locks onto the
// A0->A5 rotation, pulses each in-sequence pin and counts sequence errors.
module pin_scan_reader
  import pin_scan_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_LIMIT  = 3,
  parameter int ERR_WIDTH   = 8
) (
  input  logic                 arduino_clk,
  input  logic                 reset,
  input  logic                 A0,
  input  logic                 A1,
  input  logic                 A2,
  input  logic                 A3,
  input  logic                 A4,
  input  logic                 A5,
  input  logic                 clear_err,
  output logic [IDX_W-1:0]     pin_index,
  output logic                 pin_valid,
  output logic                 frame_done,
  output logic                 locked,
  output logic [ERR_WIDTH-1:0] err_count
);

  localparam logic [3:0]       LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0]       MISS_N   = 4'(MISS_LIMIT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PINS - 1);

  pins_t            raw;
  pins_t            s;
  logic             s_ok;
  logic [IDX_W-1:0] s_idx;
  logic             is_a0;
  logic             match;

  state_t           state, state_next;
  logic [IDX_W-1:0] expected, expected_next, exp_inc;
  logic [3:0]       good_frames, good_next;
  logic [3:0]       miss, miss_next;
  logic             pv_next, fd_next, err_inc;
  logic [IDX_W-1:0] idx_next;

  assign raw = {A5, A4, A3, A2, A1, A0};

  pin_sync #(
    .STAGES (SYNC_STAGES),
    .WIDTH  (NUM_PINS)
  ) u_sync (
    .clk   (arduino_clk),
    .reset (reset),
    .d     (raw),
    .q     (s)
  );

  assign s_ok    = is_one_hot(s);
  assign s_idx   = onehot_to_index(s);
  assign is_a0   = (s == pins_t'(1));
  assign match   = s_ok && (s_idx == expected);
  assign exp_inc = (expected == LAST_IDX) ? '0 : IDX_W'(expected + 1'b1);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge arduino_clk) begin
    if (reset) state <= HUNT;
    else       state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first; a path that skips an assignment would otherwise infer a latch.
  always_comb begin
    state_next    = state;
    expected_next = expected;
    good_next     = good_frames;
    miss_next     = miss;
    case (state)
      HUNT: begin
        if (is_a0) begin
          state_next    = VERIFY;
          expected_next = IDX_W'(1);
          good_next     = '0;
        end
      end
      VERIFY: begin
        if (match) begin
          expected_next = exp_inc;
          if (s_idx == LAST_IDX) begin
            if (good_frames == LOCK_N - 4'd1) begin
              state_next = LOCKED;
              good_next  = '0;
              miss_next  = '0;
            end else begin
              good_next = good_frames + 4'd1;
            end
          end
        end else begin
          good_next = '0;
          // A stray A0 is itself a valid frame start, so restart verification on it.
          if (is_a0) begin
            expected_next = IDX_W'(1);
          end else begin
            state_next    = HUNT;
            expected_next = '0;
          end
        end
      end
      LOCKED: begin
        expected_next = exp_inc;
        if (match) begin
          miss_next = '0;
        end else if (miss == MISS_N - 4'd1) begin
          state_next    = HUNT;
          miss_next     = '0;
          expected_next = '0;
        end else begin
          miss_next = miss + 4'd1;
        end
      end
      default: begin
        state_next    = HUNT;
        expected_next = '0;
        good_next     = '0;
        miss_next     = '0;
      end
    endcase
  end

  always_comb begin
    locked   = (state == LOCKED);
    pv_next  = 1'b0;
    fd_next  = 1'b0;
    idx_next = pin_index;
    err_inc  = 1'b0;
    if (state == LOCKED) begin
      if (match) begin
        pv_next  = 1'b1;
        fd_next  = (s_idx == LAST_IDX);
        idx_next = s_idx;
      end else begin
        err_inc = 1'b1;
      end
    end
  end

  always_ff @(posedge arduino_clk) begin
    if (reset) begin
      expected    <= '0;
      good_frames <= '0;
      miss        <= '0;
      pin_valid   <= 1'b0;
      frame_done  <= 1'b0;
      pin_index   <= '0;
    end else begin
      expected    <= expected_next;
      good_frames <= good_next;
      miss        <= miss_next;
      pin_valid   <= pv_next;
      frame_done  <= fd_next;
      pin_index   <= idx_next;
    end
  end

  // Clear takes priority over a coincident error; the count survives lock loss.
  always_ff @(posedge arduino_clk) begin
    if (reset || clear_err) begin
      err_count <= '0;
    end else if (err_inc && (err_count != '1)) begin
      err_count <= err_count + ERR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pin_scan_reader.sv
// Self-checking bench for pin_scan_reader: a rule-level reference model checks
// every cycle, plus a vector table and directed lock/error/saturation sequences.
module tb_pin_scan_reader;

  localparam int SS      = 2;
  localparam int LF      = 2;
  localparam int ML      = 3;
  localparam int EW      = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  logic          arduino_clk = 1'b0;
  logic          reset       = 1'b1;
  logic          clear_err   = 1'b0;
  logic          A0 = 1'b0, A1 = 1'b0, A2 = 1'b0, A3 = 1'b0, A4 = 1'b0, A5 = 1'b0;
  logic [2:0]    pin_index;
  logic          pin_valid, frame_done, locked;
  logic [EW-1:0] err_count;

  pin_scan_reader #(
    .SYNC_STAGES (SS),
    .LOCK_FRAMES (LF),
    .MISS_LIMIT  (ML),
    .ERR_WIDTH   (EW)
  ) dut (
    .arduino_clk (arduino_clk),
    .reset       (reset),
    .A0          (A0),
    .A1          (A1),
    .A2          (A2),
    .A3          (A3),
    .A4          (A4),
    .A5          (A5),
    .clear_err   (clear_err),
    .pin_index   (pin_index),
    .pin_valid   (pin_valid),
    .frame_done  (frame_done),
    .locked      (locked),
    .err_count   (err_count)
  );

  always #5 arduino_clk = ~arduino_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Patterns still travelling through the synchroniser.
  logic [5:0] pq [$];

  // Reference model: rule-level view of the receiver.
  bit m_tracking, m_locked, m_pv, m_fd;
  int m_exp, m_good, m_miss, m_err, m_idx;

  typedef struct {
    logic [5:0] pins;
    logic       pv;
    logic       fd;
    logic       lk;
    logic [2:0] idx;
  } vec_t;
  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [5:0] oh(input int k);
    logic [5:0] one;
    one = 6'd1;
    return one << k;
  endfunction

  function automatic logic [13:0] dut_vec();
    return {pin_valid, frame_done, locked, pin_index, err_count};
  endfunction

  function automatic logic [13:0] model_vec();
    return {m_pv, m_fd, m_locked, 3'(m_idx), 8'(m_err)};
  endfunction

  task automatic model_reset();
    m_tracking = 0; m_locked = 0; m_pv = 0; m_fd = 0;
    m_exp = 0; m_good = 0; m_miss = 0; m_err = 0; m_idx = 0;
    pq.delete();
    for (int i = 0; i < SS; i++) pq.push_back(6'd0);
  endtask

  task automatic model_step(input logic [5:0] p, input logic clr);
    bit one, hit;
    int k;
    one = ($countones(p) == 1);
    k = -1;
    for (int i = 0; i < 6; i++) if (p[i]) k = i;
    hit = m_tracking && one && (k == m_exp);
    m_pv = 0;
    m_fd = 0;
    if (m_locked) begin
      if (hit) begin
        m_pv = 1; m_fd = (k == 5); m_idx = k; m_miss = 0;
      end else begin
        if (m_err < ERR_MAX) m_err++;
        m_miss++;
        if (m_miss == ML) begin
          m_locked = 0; m_tracking = 0; m_miss = 0;
        end
      end
      m_exp = (m_exp + 1) % 6;
    end else if (hit) begin
      m_exp = (m_exp + 1) % 6;
      if (k == 5) begin
        m_good++;
        if (m_good == LF) begin
          m_locked = 1; m_good = 0; m_miss = 0;
        end
      end
    end else begin
      m_good     = 0;
      m_tracking = (p == 6'd1);
      m_exp      = m_tracking ? 1 : 0;
    end
    if (clr) m_err = 0;
  endtask

  task automatic drive(input logic [5:0] p, input logic clr);
    {A5, A4, A3, A2, A1, A0} = p;
    clear_err = clr;
    @(posedge arduino_clk);
    #1;
    pq.push_back(p);
    model_step(pq.pop_front(), clr);
    check("model", 32'(dut_vec()), 32'(model_vec()));
  endtask

  task automatic drive_pin(input int k);
    drive(oh(k), 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    reset     = 1'b1;
    clear_err = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      {A5, A4, A3, A2, A1, A0} = 6'($urandom());
      @(posedge arduino_clk);
      #1;
      model_reset();
      check("reset_outputs", 32'(dut_vec()), 32'd0);
    end
    reset = 1'b0;
  endtask

  initial begin
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < 6; p++) begin
        vecs[f*6+p].pins = oh(p);
        vecs[f*6+p].pv   = (f == 2);
        vecs[f*6+p].fd   = (f == 2) && (p == 5);
        vecs[f*6+p].lk   = (f == 2) || ((f == 1) && (p == 5));
        vecs[f*6+p].idx  = (f == 2) ? 3'(p) : 3'd0;
      end
    end

    // Reset under random pins, then quiet lines after release.
    model_reset();
    do_reset(3);
    for (int i = 0; i < SS + 1; i++) begin
      drive(6'd0, 1'b0);
      check("t1_no_pulse", {pin_valid, frame_done}, 2'b00);
    end

    // Clean rotation from A0 against the vector table.
    for (int i = 0; i < 18 + SS; i++) begin
      drive(i < 18 ? vecs[i].pins : oh(i % 6), 1'b0);
      if (i >= SS)
        check("t2_table", {pin_valid, frame_done, locked, pin_index},
              {vecs[i-SS].pv, vecs[i-SS].fd, vecs[i-SS].lk, vecs[i-SS].idx});
    end

    // Rotation entering at A3: lock only after two frames from the first A0.
    do_reset(1);
    for (int k = 3; k < 6; k++) drive_pin(k);
    for (int f = 0; f < 2; f++) for (int k = 0; k < 6; k++) drive_pin(k);
    drive_pin(0);
    check("t3_before_lock", locked, 1'b0);
    drive_pin(1);
    check("t3_locked", locked, 1'b1);

    // Empty A2 slot while locked.
    drive(6'd0, 1'b0);
    drive_pin(3);
    drive_pin(4);
    check("t4_err_after_gap", {locked, pin_valid, err_count}, {1'b1, 1'b0, 8'd1});
    drive_pin(5);
    check("t4_a3_pulse", {pin_valid, pin_index}, {1'b1, 3'd3});

    // Three multi-hot samples drop lock; a clean A0 re-acquires.
    drive(oh(0), 1'b1);
    check("t5_cleared", err_count, 8'd0);
    for (int i = 0; i < 3; i++) drive(6'b010010, 1'b0);
    check("t5_first_bad", {locked, err_count}, {1'b1, 8'd1});
    drive_pin(0);
    drive_pin(1);
    check("t5_lock_lost", {locked, err_count}, {1'b0, 8'd3});
    for (int k = 2; k < 6; k++) drive_pin(k);
    for (int k = 0; k < 6; k++) drive_pin(k);
    drive_pin(0);
    drive_pin(1);
    check("t5_relocked", locked, 1'b1);

    // 300 errors without ever missing three slots in a row.
    for (int k = 2; k < 6; k++) drive_pin(k);
    for (int f = 0; f < 75; f++)
      for (int k = 0; k < 6; k++) drive((k % 3 == 0) ? oh(k) : 6'd0, 1'b0);
    drive_pin(0);
    drive_pin(1);
    check("t6_saturated", {locked, err_count}, {1'b1, 8'd255});
    drive(6'd0, 1'b0);
    drive_pin(3);
    drive(oh(4), 1'b1);
    check("t6_clear_wins", {locked, err_count}, {1'b1, 8'd0});
    drive_pin(5);
    do_reset(1);
    for (int k = 3; k < 6; k++) drive_pin(k);
    drive_pin(0);
    check("t6_reset_hunt", {locked, pin_valid}, 2'b00);

    // Randomised rotation with corruption, slips and clears.
    do_reset(2);
    begin
      int slot;
      logic [5:0] p;
      logic clr;
      slot = 0;
      for (int i = 0; i < 3000; i++) begin
        p = oh(slot);
        case ($urandom_range(0, 15))
          0: p = 6'($urandom());
          1: p = 6'd0;
          default: ;
        endcase
        clr = ($urandom_range(0, 63) == 0);
        drive(p, clr);
        slot = ($urandom_range(0, 499) == 0) ? int'($urandom_range(0, 5)) : (slot + 1) % 6;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
